pipe_rca: RTL
=============

PIPE_RCA -- requirements
Module: pipe_rca

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits.
REQ-002 SHALL have parameter CHUNK, default 4, ripple-slice width per pipeline stage; WIDTH SHALL be a multiple of CHUNK, else elaboration error.
REQ-003 SHALL derive STAGES = WIDTH/CHUNK (not overridable).
REQ-004 One clock, clk; reset is asynchronous and active-low, rst_n.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 in_valid  input  1  operands a, b, cin, sub present.
REQ-008 in_ready  output  1  block accepts operands this cycle.
REQ-009 a  input  WIDTH  operand A.
REQ-010 b  input  WIDTH  operand B.
REQ-011 cin  input  1  carry-in (add) / borrow-in (subtract).
REQ-012 sub  input  1  0 = add, 1 = subtract.
REQ-013 out_valid  output  1  result presented.
REQ-014 out_ready  input  1  downstream accepts result.
REQ-015 sum  output  WIDTH  result.
REQ-016 cout  output  1  carry-out (add) / not-borrow (subtract).
REQ-017 ovf  output  1  two's-complement signed overflow.

Function
REQ-018 Transfer in SHALL occur when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-019 Add: {cout,sum} SHALL equal a + b + cin, modulo 2^(WIDTH+1).
REQ-020 Subtract: {cout,sum} SHALL equal a + ~b + ~cin, i.e. sum = a - b - cin, cout = 1 when no borrow.
REQ-021 ovf SHALL be 1 when operand-A sign equals effective-B sign (b or ~b) and sum sign differs.
REQ-022 Stage k (0..STAGES-1) SHALL compute chunk k only, using carry registered from stage k-1; stage 0 uses cin/~cin.
REQ-023 Unprocessed upper operand chunks SHALL be skew-delayed and completed lower sum chunks deskew-delayed so each result leaves aligned.
REQ-024 Latency SHALL be exactly STAGES cycles from accept to out_valid without backpressure.
REQ-025 Throughput SHALL be one operation per cycle while out_ready = 1.
REQ-026 Pipeline advance enable = out_ready || !out_valid; all stages, including per-stage valid bits, hold when enable = 0.
REQ-027 in_ready SHALL equal the advance enable (combinational from out_ready and out_valid).
REQ-028 While stalled, sum, cout, ovf SHALL stay stable and out_valid SHALL stay 1.
REQ-029 Bubbles (in_valid = 0 when accepting) SHALL propagate as invalid stages, never squashed or reordered.
REQ-030 Results SHALL leave in acceptance order; no operation dropped or duplicated.
REQ-031 CHUNK = WIDTH (STAGES = 1) SHALL give latency 1 with identical behaviour.

Reset
REQ-032 rst_n low SHALL immediately clear all stage valids; out_valid = 0, sum = 0, cout = 0, ovf = 0.
REQ-033 in_ready SHALL be 1 during and after reset.
REQ-034 Reset mid-operation SHALL discard all in-flight operations; none emerge after release.
REQ-035 First acceptance is permitted on the first rising edge after rst_n deasserts.

Structure
REQ-036 Package pipe_rca_pkg SHALL hold default WIDTH, default CHUNK, and the add/subtract mode constants.
REQ-037 Sub-module rca_slice SHALL be a combinational CHUNK-bit ripple-carry adder built from full-adder cells, instantiated once per stage.
REQ-038 All registers in pipe_rca; rca_slice holds none.

Verification (WIDTH=16, CHUNK=4, latency 4)
REQ-039 Reset then a=0x0001, b=0x0001, cin=0, sub=0 -> cycle 4: sum=0x0002, cout=0, ovf=0.
REQ-040 a=0xFFFF, b=0x0000, cin=1, add -> sum=0x0000, cout=1, ovf=0 (full carry ripple across all stages).
REQ-041 a=0x7FFF, b=0x0001, cin=0, add -> sum=0x8000, cout=0, ovf=1; then a=0x0005, b=0x0007, cin=0, sub=1 -> sum=0xFFFE, cout=0, ovf=0.
REQ-042 Back-to-back 8 ops with out_ready held 0 for 3 cycles mid-stream -> in_ready=0 during the stall, outputs stable, all 8 results in order, none lost.
REQ-043 rst_n pulsed low with 3 ops in flight -> out_valid=0 immediately; nothing emerges after release; the next op returns correctly at latency 4.
REQ-044 Random 10k ops with random in_valid/out_ready -> every result matches the reference model of REQ-019..021.

Source files
------------

// File: rtl/pipe_rca_pkg.sv
// pipe_rca_pkg: default sizing and add/subtract mode encoding for the pipelined ripple-carry adder
package pipe_rca_pkg;
  localparam int WIDTH_DEF = 16;
  localparam int CHUNK_DEF = 4;
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;
endpackage

// File: rtl/rca_slice.sv
// rca_slice: combinational CHUNK-bit ripple-carry adder built from full-adder cells
module rca_slice #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);
  logic [CHUNK:0] c;
  assign c[0] = ci;
  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign co = c[CHUNK];
endmodule

// File: rtl/pipe_rca.sv
// pipe_rca: pipelined add/subtract unit, one CHUNK-bit ripple slice per stage with valid/ready flow control
module pipe_rca
  import pipe_rca_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CHUNK = CHUNK_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int STAGES = WIDTH / CHUNK;
  localparam int L = STAGES - 1;
  localparam logic [WIDTH-1:0] CMASK = WIDTH'({CHUNK{1'b1}});
  if (WIDTH % CHUNK != 0) begin : g_bad_cfg
    $error("pipe_rca: WIDTH must be a multiple of CHUNK");
  end
  logic en;
  logic [WIDTH-1:0] ra [STAGES];
  logic [WIDTH-1:0] rb [STAGES];
  logic [WIDTH-1:0] rs [STAGES];
  logic [STAGES-1:0] rc, rv;
  logic [WIDTH-1:0] xa [STAGES];
  logic [WIDTH-1:0] xb [STAGES];
  logic [WIDTH-1:0] xs [STAGES];
  logic [WIDTH-1:0] ns [STAGES];
  logic [STAGES-1:0] xc, xv, sc;
  logic [CHUNK-1:0] ss [STAGES];
  assign en = out_ready || !out_valid;
  assign in_ready = en;
  // Stage 0 sees the raw operands; subtraction is folded into B and the carry-in here.
  assign xa[0] = a;
  assign xb[0] = (sub == MODE_SUB) ? ~b : b;
  assign xs[0] = '0;
  assign xc[0] = (sub == MODE_ADD) ? cin : ~cin;
  assign xv[0] = in_valid;
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    if (k > 0) begin : g_link
      assign xa[k] = ra[k-1];
      assign xb[k] = rb[k-1];
      assign xs[k] = rs[k-1];
      assign xc[k] = rc[k-1];
      assign xv[k] = rv[k-1];
    end
    rca_slice #(.CHUNK(CHUNK)) u_slice (
      .a (xa[k][k*CHUNK +: CHUNK]),
      .b (xb[k][k*CHUNK +: CHUNK]),
      .ci(xc[k]),
      .s (ss[k]),
      .co(sc[k])
    );
    assign ns[k] = (xs[k] & ~(CMASK << (k*CHUNK))) | (WIDTH'(ss[k]) << (k*CHUNK));
  end
  // Stage registers: operands travel whole (skew), finished chunks accumulate in rs (deskew); all hold on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        ra[k] <= '0;
        rb[k] <= '0;
        rs[k] <= '0;
      end
      rc <= '0;
      rv <= '0;
    end else if (en) begin
      for (int k = 0; k < STAGES; k++) begin
        ra[k] <= xa[k];
        rb[k] <= xb[k];
        rs[k] <= ns[k];
      end
      rc <= sc;
      rv <= xv;
    end
  end
  assign out_valid = rv[L];
  assign sum = rs[L];
  assign cout = rc[L];
  assign ovf = (ra[L][WIDTH-1] == rb[L][WIDTH-1]) && (rs[L][WIDTH-1] != ra[L][WIDTH-1]);
endmodule
